// File: rtl/mp_pkg.sv
// Shared defaults and FSM encoding for the load/store unit.
package mp_pkg;

   localparam int LSU_DATA_W    = 8;
   localparam int LSU_ADDR_W    = 8;
   localparam int LSU_MEM_DEPTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; load 3 cycles, store 2, fault/nop 1 from accept to wb_valid.
// Holds the result in RESP until wb_ready; op_ready only in IDLE, so nothing is queued.
module load_store_unit
   import mp_pkg::*;
#(
   parameter int DATA_W    = LSU_DATA_W,
   parameter int ADDR_W    = LSU_ADDR_W,
   parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_load,
   input  logic              op_store,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [DATA_W-1:0] op_wdata,
   input  logic [1:0]        op_rd,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_wen,
   output logic [1:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_err,
   output logic [7:0]        err_count
);

   lsu_state_t        r_state;
   lsu_state_t        w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_rd;
   logic              r_is_load;
   logic              r_is_store;
   logic              r_err;
   logic [7:0]        r_err_count;

   logic w_accept;
   logic w_fault;
   logic w_mem_op;

   assign w_accept = op_valid && (r_state == ST_IDLE);
   assign w_fault  = (32'(op_addr) >= MEM_DEPTH) || (op_load && op_store);
   assign w_mem_op = !w_fault && (op_load || op_store);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = w_mem_op ? ST_ACCESS : ST_RESP;
         ST_ACCESS:  w_next = r_is_load ? ST_CAPTURE : ST_RESP;
         ST_CAPTURE: w_next = ST_RESP;
         ST_RESP:    if (wb_ready) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      op_ready  = (r_state == ST_IDLE);
      mem_read  = (r_state == ST_ACCESS) && r_is_load;
      mem_write = (r_state == ST_ACCESS) && r_is_store;
      wb_valid  = (r_state == ST_RESP);
   end

   // Kind flags are cleared on a fault so a faulted op can never strobe memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_data     <= '0;
         r_rd       <= '0;
         r_is_load  <= 1'b0;
         r_is_store <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_addr     <= op_addr;
         r_wdata    <= op_wdata;
         r_data     <= '0;
         r_rd       <= op_rd;
         r_is_load  <= op_load && !w_fault;
         r_is_store <= op_store && !w_fault;
         r_err      <= w_fault;
      end else if (r_state == ST_CAPTURE) begin
         r_data     <= mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    r_err_count <= '0;
      else if (w_accept && w_fault && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
   end

   assign mem_address = r_addr;
   assign mem_wdata   = r_wdata;
   assign wb_wen      = r_is_load;
   assign wb_rd       = r_rd;
   assign wb_data     = r_data;
   assign wb_err      = r_err;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a synchronous data memory and an op-level reference model.
module tb_load_store_unit;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int MD = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          op_valid, op_ready, op_load, op_store;
   logic [AW-1:0] op_addr;
   logic [DW-1:0] op_wdata;
   logic [1:0]    op_rd;
   logic [AW-1:0] mem_address;
   logic          mem_read, mem_write;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          wb_valid, wb_ready, wb_wen, wb_err;
   logic [1:0]    wb_rd;
   logic [DW-1:0] wb_data;
   logic [7:0]    err_count;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(MD)) dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load), .op_store(op_store),
      .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_err(wb_err), .err_count(err_count)
   );

   // Data memory device: one-cycle synchronous read, write on the strobe edge.
   logic [DW-1:0] dmem    [0:MD-1];
   logic [DW-1:0] ref_mem [0:MD-1];
   int            exp_err = 0;
   int            n_checks = 0;
   int            n_pass = 0;

   always @(posedge clk) begin
      if (mem_read && int'(mem_address) < MD)  mem_rdata <= dmem[mem_address];
      if (mem_write && int'(mem_address) < MD) dmem[mem_address] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation end to end; the model predicts latency, strobes and writeback from the op rules.
   task automatic do_op(input logic l, input logic s, input logic [7:0] a, input logic [7:0] wd,
                        input logic [1:0] rd, input int stall);
      logic       fault;
      logic       is_load, is_store;
      int         exp_lat, cyc, t, n_rd, n_wr, bad, bad_stall;
      logic [7:0] exp_data;
      logic [12:0] snap;
      fault    = (int'(a) >= MD) || (l && s);
      is_load  = l && !fault;
      is_store = s && !fault;
      exp_lat  = is_load ? 3 : (is_store ? 2 : 1);
      exp_data = is_load ? ref_mem[a[4:0]] : 8'h00;
      if (fault && exp_err < 255) exp_err++;
      n_rd = 0; n_wr = 0; bad = 0; bad_stall = 0;

      t = 0;
      while (!op_ready && t < 20) begin tick(); t++; end
      check("op_ready_idle", 32'(op_ready), 32'd1);

      op_valid = 1'b1; op_load = l; op_store = s; op_addr = a; op_wdata = wd; op_rd = rd;
      wb_ready = 1'b0;
      tick();
      // junk op held valid while busy must be ignored
      op_valid = 1'b1; op_load = 1'($urandom); op_store = 1'($urandom);
      op_addr = 8'($urandom); op_wdata = 8'($urandom); op_rd = 2'($urandom);

      cyc = 1;
      while (!wb_valid && cyc < 8) begin
         if (mem_read) n_rd++;
         if (mem_write) n_wr++;
         if (mem_read && mem_write) bad++;
         if ((mem_read || mem_write) && mem_address != a) bad++;
         if (mem_write && mem_wdata != wd) bad++;
         if (op_ready) bad++;
         tick();
         cyc++;
      end
      if (mem_read || mem_write) bad++;
      check("latency", 32'(cyc), 32'(exp_lat));
      check("wb_valid", 32'(wb_valid), 32'd1);
      check("wb_err", 32'(wb_err), 32'(fault));
      check("wb_wen", 32'(wb_wen), 32'(is_load));
      check("wb_data", 32'(wb_data), 32'(exp_data));
      if (is_load) check("wb_rd", 32'(wb_rd), 32'(rd));
      check("n_mem_read", 32'(n_rd), 32'(is_load));
      check("n_mem_write", 32'(n_wr), 32'(is_store));
      check("strobe_rules", 32'(bad), 32'd0);
      check("err_count", 32'(err_count), 32'(exp_err));

      snap = {wb_err, wb_wen, wb_rd, wb_data, op_ready};
      for (int i = 0; i < stall; i++) begin
         tick();
         if (!wb_valid || snap != {wb_err, wb_wen, wb_rd, wb_data, op_ready} || op_ready) bad_stall++;
      end
      if (stall > 0) check("stall_hold", 32'(bad_stall), 32'd0);

      op_valid = 1'b0;
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      check("post_hs_wb_valid", 32'(wb_valid), 32'd0);
      check("post_hs_op_ready", 32'(op_ready), 32'd1);

      if (is_store) ref_mem[a[4:0]] = wd;
   endtask

   initial begin
      int wb_seen;
      logic [7:0] a;
      int kind;
      for (int i = 0; i < 16; i++) begin
         dmem[i] = 8'(i);        ref_mem[i] = 8'(i);
         dmem[16+i] = 8'(-i);    ref_mem[16+i] = 8'(-i);
      end
      mem_rdata = '0;
      reset = 1'b1; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
      op_addr = '0; op_wdata = '0; op_rd = '0; wb_ready = 1'b0;
      #1;
      check("rst_op_ready", 32'(op_ready), 32'd1);
      check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_wb", 32'({wb_valid, wb_wen, wb_err, wb_rd, wb_data}), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Directed cases
      do_op(1'b1, 1'b0, 8'h05, 8'h00, 2'd1, 0);
      do_op(1'b1, 1'b0, 8'h11, 8'h00, 2'd2, 0);
      do_op(1'b1, 1'b0, 8'h1F, 8'h00, 2'd3, 0);
      do_op(1'b0, 1'b1, 8'h03, 8'hA5, 2'd0, 0);
      do_op(1'b1, 1'b0, 8'h03, 8'h00, 2'd1, 0);
      check("dmem_store_03", 32'(dmem[3]), 32'hA5);
      do_op(1'b0, 1'b0, 8'h07, 8'h33, 2'd0, 0);
      do_op(1'b1, 1'b0, 8'h40, 8'h00, 2'd0, 0);
      do_op(1'b1, 1'b1, 8'h02, 8'h11, 2'd0, 0);
      check("err_count_two", 32'(err_count), 32'd2);
      do_op(1'b1, 1'b0, 8'h09, 8'h00, 2'd2, 5);

      // Reset during the ACCESS cycle of a load
      op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_addr = 8'h0A; op_rd = 2'd3;
      tick();
      op_valid = 1'b0;
      check("midrst_in_access", 32'(mem_read), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_strobes", 32'({mem_read, mem_write}), 32'd0);
      check("midrst_outputs", 32'({wb_valid, wb_wen, wb_err, wb_rd, wb_data, mem_address}), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      check("midrst_op_ready", 32'(op_ready), 32'd1);
      exp_err = 0;
      @(negedge clk);
      reset = 1'b0;
      wb_seen = 0;
      repeat (6) begin tick(); if (wb_valid) wb_seen++; end
      check("midrst_no_wb", 32'(wb_seen), 32'd0);
      check("midrst_ready_after", 32'(op_ready), 32'd1);

      // Randomized mix biased toward legal loads and stores
      for (int n = 0; n < 150; n++) begin
         kind = int'($urandom_range(0, 9));
         a = (kind == 9) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, MD - 1));
         do_op(kind < 4 || kind == 8, (kind >= 4 && kind < 7) || kind == 8, a,
               8'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
      end

      // Saturation
      for (int n = 0; n < 300; n++) begin
         do_op(1'b1, 1'b1, 8'($urandom), 8'h00, 2'd0, 0);
      end
      check("err_count_saturated", 32'(err_count), 32'd255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
